// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//   Synchronizes, debounces and classifies a raw mechanical push-button.
//   The raw pin passes through a two-flop synchronizer, is normalized so that
//   1 always means "pressed", and drives a four-state debounce FSM. Every
//   output comes straight from a flop.
//
// Parameters
//   DEBOUNCE   : consecutive stable samples needed to accept a change (>= 2)
//   LONGPRESS  : cycles held after the press pulse before long_press_o fires;
//                0 disables long_press_o
//   ACTIVE_LOW : 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//
// Ports
//   clk          : system clock, all state on rising edge
//   clr_n        : asynchronous active-low reset
//   btn_i        : raw, asynchronous, bouncing button pin
//   pressed_o    : debounced level, 1 while the button is accepted as down
//   press_o      : one-cycle pulse on accepted press
//   release_o    : one-cycle pulse on accepted release
//   long_press_o : one-cycle pulse, at most once per press, when the hold
//                  time reaches LONGPRESS
// -----------------------------------------------------------------------------
module button_reader #(
    parameter int unsigned DEBOUNCE   = 1000000,
    parameter int unsigned LONGPRESS  = 100000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
    localparam int unsigned HOLD_W = (LONGPRESS == 0) ? 1 : $clog2(LONGPRESS + 1);

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DB_DOWN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_DB_UP   = 2'd3
    } state_e;

    logic [1:0]        sync_q;
    state_e            state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              pressed_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;

    logic              s_c;
    logic              db_last_c;
    logic              hold_sat_c;
    logic [HOLD_W-1:0] hold_nxt_c;
    logic              long_hit_c;

    // Two-flop synchronizer; resets to the released pin level so a reset
    // never looks like a press.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= {2{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Normalized sample: 1 means pressed regardless of pin polarity.
    assign s_c = sync_q[1] ^ ACTIVE_LOW;

    // Current sample is the DEBOUNCE-th consecutive one in the new direction.
    assign db_last_c = (db_cnt_q == DB_W'(DEBOUNCE - 1));

    // Hold counter saturates at LONGPRESS so it never wraps; long_press fires
    // on the single increment that lands exactly on LONGPRESS.
    assign hold_sat_c = (hold_q == HOLD_W'(LONGPRESS));
    assign hold_nxt_c = hold_sat_c ? hold_q : (hold_q + HOLD_W'(1));
    assign long_hit_c = (LONGPRESS != 0) && (hold_q == HOLD_W'(LONGPRESS - 1));

    // Debounce / classification FSM with registered pulse outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_UP;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                ST_UP: begin
                    if (s_c) begin
                        state_q  <= ST_DB_DOWN;
                        db_cnt_q <= DB_W'(1);
                    end
                end
                ST_DB_DOWN: begin
                    if (!s_c) begin
                        // Bounce rejected, nothing visible changes.
                        state_q  <= ST_UP;
                        db_cnt_q <= '0;
                    end else if (db_last_c) begin
                        state_q   <= ST_DOWN;
                        db_cnt_q  <= '0;
                        hold_q    <= '0;
                        pressed_q <= 1'b1;
                        press_q   <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                ST_DOWN: begin
                    hold_q <= hold_nxt_c;
                    long_q <= long_hit_c;
                    if (!s_c) begin
                        state_q  <= ST_DB_UP;
                        db_cnt_q <= DB_W'(1);
                    end
                end
                ST_DB_UP: begin
                    if (s_c) begin
                        // Release glitch: resume DOWN, hold timing keeps running.
                        state_q  <= ST_DOWN;
                        db_cnt_q <= '0;
                        hold_q   <= hold_nxt_c;
                        long_q   <= long_hit_c;
                    end else if (db_last_c) begin
                        // Release wins this cycle, keeping pulses exclusive.
                        state_q   <= ST_UP;
                        db_cnt_q  <= '0;
                        hold_q    <= '0;
                        pressed_q <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                        hold_q   <= hold_nxt_c;
                        long_q   <= long_hit_c;
                    end
                end
                default: begin
                    state_q  <= ST_UP;
                    db_cnt_q <= '0;
                    hold_q   <= '0;
                end
            endcase
        end
    end

    assign pressed_o    = pressed_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: tb/tb_button_reader.sv
// -----------------------------------------------------------------------------
// tb_button_reader
//   Drives two button_reader instances (LONGPRESS=20 and LONGPRESS=0) from the
//   same pin and compares them every cycle with a run-length reference model.
// -----------------------------------------------------------------------------
module tb_button_reader;

    localparam int unsigned DEB = 4;
    localparam int unsigned LP  = 20;

    logic clk = 1'b0;
    logic clr_n;
    logic btn;

    logic pressed_a, press_a, release_a, long_a;
    logic pressed_b, press_b, release_b, long_b;

    int checks = 0;
    int errors = 0;

    button_reader #(.DEBOUNCE(DEB), .LONGPRESS(LP), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .clr_n(clr_n), .btn_i(btn),
        .pressed_o(pressed_a), .press_o(press_a),
        .release_o(release_a), .long_press_o(long_a)
    );

    button_reader #(.DEBOUNCE(DEB), .LONGPRESS(0), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .clr_n(clr_n), .btn_i(btn),
        .pressed_o(pressed_b), .press_o(press_b),
        .release_o(release_b), .long_press_o(long_b)
    );

    always #5 clk = ~clk;

    // Reference model: pin samples delayed two edges, accepted level flips
    // after DEB consecutive samples disagreeing with it.
    bit pipe[$];
    bit m_level;
    int m_run;
    int m_t;
    int m_press_t;
    bit m_press, m_rel, m_long;

    function automatic logic [3:0] act_a();
        return {pressed_a, press_a, release_a, long_a};
    endfunction

    function automatic logic [3:0] act_b();
        return {pressed_b, press_b, release_b, long_b};
    endfunction

    function automatic logic [3:0] exp_a();
        return {m_level, m_press, m_rel, m_long};
    endfunction

    function automatic logic [3:0] exp_b();
        return {m_level, m_press, m_rel, 1'b0};
    endfunction

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(1'b1);
        pipe.push_back(1'b1);
        m_level   = 1'b0;
        m_run     = 0;
        m_t       = 0;
        m_press_t = -1000000;
        m_press   = 1'b0;
        m_rel     = 1'b0;
        m_long    = 1'b0;
    endtask

    // Drive the pin, advance one edge, update the model, settle 1ns.
    task automatic tick(input bit b);
        bit s;
        btn = b;
        @(posedge clk);
        s = (pipe.pop_front() == 1'b0);
        pipe.push_back(b);
        m_t++;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == int'(DEB)) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_press   = 1'b1;
                    m_press_t = m_t;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        if (m_level && !m_press && (m_t - m_press_t) == int'(LP))
            m_long = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        btn   = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (act_a() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_a cycle %0d: got %b want 0000", i, act_a());
            end
            checks++;
            if (act_b() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_b cycle %0d: got %b want 0000", i, act_b());
            end
            @(posedge clk);
            #1;
        end
        clr_n = 1'b1;
    endtask

    task automatic test_press_latency();
        int press_at, long_at, rel_at, n_press, n_rel, n_long;
        press_at = -1; long_at = -1; rel_at = -1;
        n_press = 0; n_rel = 0; n_long = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL idle tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
        end
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL latency tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
            if (press_a) begin n_press++; if (press_at < 0) press_at = i; end
            if (long_a)  begin n_long++;  if (long_at < 0)  long_at  = i; end
            if (release_a) n_rel++;
        end
        checks++;
        if (press_at !== 6) begin
            errors++;
            $display("FAIL press_latency: got tick %0d want 6", press_at);
        end
        checks++;
        if (long_at !== 26) begin
            errors++;
            $display("FAIL long_latency: got tick %0d want 26", long_at);
        end
        checks++;
        if (n_press !== 1 || n_long !== 1 || n_rel !== 0) begin
            errors++;
            $display("FAIL latency_pulses: got press %0d long %0d rel %0d want 1 1 0", n_press, n_long, n_rel);
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL unpress tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
            if (release_a && rel_at < 0) rel_at = i;
        end
        checks++;
        if (rel_at !== 6) begin
            errors++;
            $display("FAIL release_latency: got tick %0d want 6", rel_at);
        end
    endtask

    task automatic test_bounce_reject();
        int n_press;
        bit seen_pressed;
        n_press = 0; seen_pressed = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick(i <= 3 ? 1'b0 : 1'b1);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL bounce tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
            if (press_a) n_press++;
            if (pressed_a) seen_pressed = 1'b1;
        end
        checks++;
        if (n_press !== 0 || seen_pressed !== 1'b0) begin
            errors++;
            $display("FAIL bounce_reject: got press %0d pressed %0b want 0 0", n_press, seen_pressed);
        end
    endtask

    task automatic test_glitch_hold();
        int long_at, n_rel, n_long;
        long_at = -1; n_rel = 0; n_long = 0;
        for (int i = 1; i <= 40; i++) begin
            tick((i == 11 || i == 12) ? 1'b1 : 1'b0);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL glitch tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
            if (long_a) begin n_long++; if (long_at < 0) long_at = i; end
            if (release_a) n_rel++;
        end
        checks++;
        if (long_at !== 26 || n_long !== 1 || n_rel !== 0 || pressed_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_hold: got long@%0d nlong %0d rel %0d pressed %0b want 26 1 0 1",
                     long_at, n_long, n_rel, pressed_a);
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL glitch_release tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
        end
    endtask

    task automatic test_long_hold();
        int np_a, nl_a, nr_a, np_b, nl_b, nr_b, rel_at;
        np_a = 0; nl_a = 0; nr_a = 0; np_b = 0; nl_b = 0; nr_b = 0; rel_at = -1;
        for (int i = 1; i <= 118; i++) begin
            tick(i <= 106 ? 1'b0 : 1'b1);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL long_hold tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
            if (press_a) np_a++;
            if (long_a) nl_a++;
            if (release_a) begin nr_a++; if (rel_at < 0) rel_at = i - 106; end
            if (press_b) np_b++;
            if (long_b) nl_b++;
            if (release_b) nr_b++;
        end
        checks++;
        if (np_a !== 1 || nl_a !== 1 || nr_a !== 1 || rel_at !== 6) begin
            errors++;
            $display("FAIL long_hold_a: got press %0d long %0d rel %0d rel_at %0d want 1 1 1 6",
                     np_a, nl_a, nr_a, rel_at);
        end
        checks++;
        if (np_b !== 1 || nl_b !== 0 || nr_b !== 1) begin
            errors++;
            $display("FAIL long_disabled_b: got press %0d long %0d rel %0d want 1 0 1", np_b, nl_b, nr_b);
        end
    endtask

    task automatic test_reset_mid_press();
        int press_at, n_rel;
        press_at = -1; n_rel = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL pre_reset tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
        end
        checks++;
        if (pressed_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pressed: got %0b want 1", pressed_a);
        end
        clr_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a() !== 4'b0000 || act_b() !== 4'b0000) begin
                errors++;
                $display("FAIL mid_reset cycle %0d: got %b/%b want 0000/0000", i, act_a(), act_b());
            end
            @(posedge clk);
            #1;
        end
        clr_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL post_reset tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
            if (press_a && press_at < 0) press_at = i;
            if (release_a) n_rel++;
        end
        checks++;
        if (press_at !== 6 || n_rel !== 0) begin
            errors++;
            $display("FAIL reset_repress: got press@%0d rel %0d want 6 0", press_at, n_rel);
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1);
            checks++;
            if (act_a() !== exp_a() || act_b() !== exp_b()) begin
                errors++;
                $display("FAIL reset_release tick %0d: got %b/%b want %b/%b", i, act_a(), act_b(), exp_a(), exp_b());
            end
        end
    endtask

    task automatic test_random();
        int remaining;
        int len;
        bit lvl;
        remaining = 1500;
        lvl = 1'b0;
        while (remaining > 0) begin
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(10, 40));
            else len = int'($urandom_range(1, 7));
            for (int j = 0; j < len && remaining > 0; j++) begin
                tick(lvl);
                remaining--;
                checks++;
                if (act_a() !== exp_a()) begin
                    errors++;
                    $display("FAIL random_a t %0d: got %b want %b", m_t, act_a(), exp_a());
                end
                checks++;
                if (act_b() !== exp_b()) begin
                    errors++;
                    $display("FAIL random_b t %0d: got %b want %b", m_t, act_b(), exp_b());
                end
                checks++;
                if ((int'(press_a) + int'(release_a) + int'(long_a)) > 1) begin
                    errors++;
                    $display("FAIL random_exclusive t %0d: got %b%b%b want at most one",
                             m_t, press_a, release_a, long_a);
                end
            end
            lvl = ~lvl;
        end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_bounce_reject();
        test_glitch_hold();
        test_long_hold();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
